// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - calibratable tick / blink / tick-count timebase
//
// Purpose:
//   Divides i_clk into a single-cycle tick every `per` enabled cycles, a
//   registered half-period square wave, and a wrapping tick count with a
//   carry pulse. The active period register `per` reloads only at reset,
//   on a synchronous clear and at the end of a period. Mid-period changes
//   to i_fast / i_trim therefore never distort the period in flight.
//
// Build option:
//   TICK_GEN_TRIM_EN - when defined, adds the signed i_trim port and makes
//                      the normal period DIV+i_trim (clamped to >= 2).
//                      When undefined the normal period is fixed at DIV.
//
// Ports:
//   i_clk    in   1              system clock (only clock)
//   i_rst_n  in   1              asynchronous active-low reset
//   i_en     in   1              count enable, low = pause (state holds)
//   i_clr    in   1              synchronous phase clear, beats i_en
//   i_fast   in   1              select set-mode period DIV/FAST_DIV
//   i_trim   in   TRIM_W         signed period correction (trim build only)
//   o_tick   out  1              one-cycle pulse per period
//   o_half   out  1              high for the first floor(per/2) cycles
//   o_count  out  $clog2(WRAP)   tick count modulo WRAP
//   o_wrap   out  1              pulse with the tick that wraps o_count
module tick_generator #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int FAST_DIV = 16,
  parameter int WRAP     = 60,
  parameter int TRIM_W   = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic                      i_fast,
`ifdef TICK_GEN_TRIM_EN
  input  logic signed [TRIM_W-1:0]  i_trim,
`endif
  output logic                      o_tick,
  output logic                      o_half,
  output logic [$clog2(WRAP)-1:0]   o_count,
  output logic                      o_wrap
);

  // Nominal and set-mode periods in clock cycles.
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int FDIV = DIV / FAST_DIV;

`ifdef TICK_GEN_TRIM_EN
  localparam bit TRIM_EN = 1'b1;
`else
  localparam bit TRIM_EN = 1'b0;
`endif

  // Largest period the counter must hold: a positive trim can stretch the
  // period by up to 2^(TRIM_W-1)-1 cycles; without trim only DIV is needed.
  localparam int TRIM_HEADROOM = TRIM_EN ? (2 ** (TRIM_W - 1)) : 0;
  localparam int PER_MAX       = DIV + TRIM_HEADROOM;
  localparam int CNT_W         = $clog2(PER_MAX + 1);
  localparam int COUNT_W       = $clog2(WRAP);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]   r_cnt;     // phase within the current period
  logic [CNT_W-1:0]   r_per;     // period in effect for this period
  logic [COUNT_W-1:0] r_count;   // ticks modulo WRAP
  logic               r_tick;
  logic               r_wrap;
  logic               r_half;

  // ---------------------------------------------------------------------
  // Period selection (sampled only when r_per reloads)
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]   w_sel_per;
  logic [CNT_W-1:0]   w_norm_per;

`ifdef TICK_GEN_TRIM_EN
  // Two extra bits keep the signed sum free of overflow for any trim
  // value, so the clamp below sees the true arithmetic result.
  localparam int SUM_W = CNT_W + 2;
  logic signed [SUM_W-1:0] w_trim_sum;

  assign w_trim_sum = $signed(SUM_W'(DIV)) + SUM_W'(i_trim);
  assign w_norm_per = (w_trim_sum < $signed(SUM_W'(2))) ? CNT_W'(2)
                                                         : w_trim_sum[CNT_W-1:0];
`else
  assign w_norm_per = CNT_W'(DIV);
`endif

  // Set-mode rate ignores trim entirely.
  assign w_sel_per = i_fast ? CNT_W'(FDIV) : w_norm_per;

  // ---------------------------------------------------------------------
  // Next-state logic: clear beats enable beats hold
  // ---------------------------------------------------------------------
  logic               w_at_tc;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_per_nxt;
  logic [COUNT_W-1:0] w_count_nxt;
  logic               w_tick_nxt;
  logic               w_wrap_nxt;
  logic               w_half_nxt;

  // Terminal count is per-1; comparing cnt+1 against per avoids a
  // separate subtractor and gives an exact per-cycle period.
  assign w_at_tc = ((r_cnt + CNT_W'(1)) == r_per);

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = r_per;
    w_count_nxt = r_count;
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (i_clr) begin
      // Clear wins even over a coinciding period end: no tick, no wrap.
      w_cnt_nxt   = '0;
      w_per_nxt   = w_sel_per;
      w_count_nxt = '0;
    end else if (i_en) begin
      if (w_at_tc) begin
        w_cnt_nxt  = '0;
        w_per_nxt  = w_sel_per;
        w_tick_nxt = 1'b1;
        if (r_count == COUNT_W'(WRAP - 1)) begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + COUNT_W'(1);
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // Uses the period in effect after this edge so the first cycle of a
  // freshly loaded period already reflects the new half length. While
  // paused cnt and per hold, so this reproduces the held value.
  assign w_half_nxt = (w_cnt_nxt < (w_per_nxt >> 1));

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_per   <= CNT_W'(DIV);
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_half  <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_per   <= w_per_nxt;
      r_count <= w_count_nxt;
      r_tick  <= w_tick_nxt;
      r_wrap  <= w_wrap_nxt;
      r_half  <= w_half_nxt;
    end
  end

  assign o_tick  = r_tick;
  assign o_wrap  = r_wrap;
  assign o_half  = r_half;
  assign o_count = r_count;

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - self-checking bench for tick_generator
`timescale 1ns/1ps
module tb_tick_generator;

  localparam int CLK_HZ   = 20;
  localparam int TICK_HZ  = 2;
  localparam int FAST_DIV = 5;
  localparam int WRAP     = 3;
  localparam int TRIM_W   = 4;
  localparam int DIV      = CLK_HZ / TICK_HZ;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       clr   = 1'b0;
  logic       fast  = 1'b0;
`ifdef TICK_GEN_TRIM_EN
  logic signed [TRIM_W-1:0] trim = '0;
`endif
  logic       tick;
  logic       half;
  logic       wrap;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  tick_generator #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .FAST_DIV (FAST_DIV),
    .WRAP     (WRAP),
    .TRIM_W   (TRIM_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_clr   (clr),
    .i_fast  (fast),
`ifdef TICK_GEN_TRIM_EN
    .i_trim  (trim),
`endif
    .o_tick  (tick),
    .o_half  (half),
    .o_count (count),
    .o_wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: elapsed enabled cycles in the period, period length
  // and total ticks; outputs follow arithmetically from those.
  // ---------------------------------------------------------------------
  int m_phase = 0;
  int m_per   = DIV;
  int m_ticks = 0;
  int m_tick  = 0;
  int m_wrap  = 0;

  function automatic int cur_trim();
`ifdef TICK_GEN_TRIM_EN
    return int'(trim);
`else
    return 0;
`endif
  endfunction

  function automatic int sel_period(input bit f, input int t);
    int p;
    if (f) return DIV / FAST_DIV;
    p = DIV + t;
    return (p < 2) ? 2 : p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_per   <= DIV;
      m_ticks <= 0;
      m_tick  <= 0;
      m_wrap  <= 0;
    end else if (clr) begin
      m_phase <= 0;
      m_per   <= sel_period(fast, cur_trim());
      m_ticks <= 0;
      m_tick  <= 0;
      m_wrap  <= 0;
    end else if (en) begin
      if (m_phase + 1 == m_per) begin
        m_phase <= 0;
        m_per   <= sel_period(fast, cur_trim());
        m_ticks <= m_ticks + 1;
        m_tick  <= 1;
        m_wrap  <= (((m_ticks + 1) % WRAP) == 0) ? 1 : 0;
      end else begin
        m_phase <= m_phase + 1;
        m_tick  <= 0;
        m_wrap  <= 0;
      end
    end else begin
      m_tick <= 0;
      m_wrap <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_tick",  int'(tick),  m_tick);
      chk("cmp_wrap",  int'(wrap),  m_wrap);
      chk("cmp_count", int'(count), m_ticks % WRAP);
      chk("cmp_half",  int'(half),  (m_phase < m_per / 2) ? 1 : 0);
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with hand-computed literal expectations
  // ---------------------------------------------------------------------
  initial begin
    wait_n(2);
    chk("rst_tick",  int'(tick),  0);
    chk("rst_wrap",  int'(wrap),  0);
    chk("rst_count", int'(count), 0);
    chk("rst_half",  int'(half),  1);

    // Free run: ticks at cycles 10, 20, 30; count 1, 2, 0.
    rst_n = 1'b1;
    en    = 1'b1;
    wait_n(4);  chk("s1_half_c4", int'(half), 1);
    wait_n(1);  chk("s1_half_c5", int'(half), 0);
    wait_n(4);  chk("s1_tick_c9", int'(tick), 0);
    wait_n(1);  chk("s1_tick_c10", int'(tick), 1);
    chk("s1_count_c10", int'(count), 1);
    chk("s1_wrap_c10",  int'(wrap),  0);
    wait_n(10); chk("s1_tick_c20", int'(tick), 1);
    chk("s1_count_c20", int'(count), 2);
    wait_n(10); chk("s1_tick_c30", int'(tick), 1);
    chk("s1_count_c30", int'(count), 0);
    chk("s1_wrap_c30",  int'(wrap),  1);

    // Pause 7 cycles at phase 4: tick 7 cycles late.
    wait_n(4);
    en = 1'b0;
    wait_n(7);
    chk("s2_pause_tick", int'(tick), 0);
    chk("s2_pause_half", int'(half), 1);
    en = 1'b1;
    wait_n(5);  chk("s2_tick_early", int'(tick), 0);
    wait_n(1);  chk("s2_tick_late",  int'(tick), 1);
    chk("s2_count", int'(count), 1);

    // Fast mode requested at phase 3: current period still 10.
    wait_n(3);
    fast = 1'b1;
    wait_n(6);  chk("s3_tick_hold", int'(tick), 0);
    wait_n(1);  chk("s3_tick_end",  int'(tick), 1);
    wait_n(2);  chk("s3_fast_tick1", int'(tick), 1);
    chk("s3_fast_wrap", int'(wrap), 1);
    wait_n(2);  chk("s3_fast_tick2", int'(tick), 1);
    fast = 1'b0;
    wait_n(2);  chk("s3_still_fast", int'(tick), 1);
    wait_n(9);  chk("s3_slow_gap", int'(tick), 0);
    wait_n(1);  chk("s3_slow_tick", int'(tick), 1);
    chk("s3_count", int'(count), 0);

    // Clear at phase 9 on the edge that would wrap count 2 -> 0.
    wait_n(10);
    wait_n(10); chk("s4_count_pre", int'(count), 2);
    wait_n(9);
    clr = 1'b1;
    wait_n(1);
    clr = 1'b0;
    chk("s4_clr_tick",  int'(tick),  0);
    chk("s4_clr_wrap",  int'(wrap),  0);
    chk("s4_clr_count", int'(count), 0);
    chk("s4_clr_half",  int'(half),  1);
    wait_n(9);  chk("s4_tick_early", int'(tick), 0);
    wait_n(1);  chk("s4_tick", int'(tick), 1);
    chk("s4_count", int'(count), 1);

    // Asynchronous reset at phase 6 with count 2.
    wait_n(10); chk("s6_count_pre", int'(count), 2);
    wait_n(6);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_tick",  int'(tick),  0);
    chk("s6_rst_wrap",  int'(wrap),  0);
    chk("s6_rst_count", int'(count), 0);
    chk("s6_rst_half",  int'(half),  1);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(9);  chk("s6_tick_early", int'(tick), 0);
    wait_n(1);  chk("s6_tick", int'(tick), 1);
    chk("s6_count", int'(count), 1);

`ifdef TICK_GEN_TRIM_EN
    // Trim +3 takes effect after the next period end.
    trim = 4'sd3;
    wait_n(10); chk("s5_tick_div", int'(tick), 1);
    wait_n(12); chk("s5_gap13", int'(tick), 0);
    wait_n(1);  chk("s5_tick13", int'(tick), 1);
    trim = -4'sd8;
    wait_n(13); chk("s5_tick13b", int'(tick), 1);
    wait_n(2);  chk("s5_tick_clamp", int'(tick), 1);
    fast = 1'b1;
    trim = 4'sd7;
    wait_n(2);  chk("s5_fast_a", int'(tick), 1);
    wait_n(2);  chk("s5_fast_b", int'(tick), 1);
    fast = 1'b0;
    trim = 4'sd0;
    wait_n(2);  chk("s5_fast_c", int'(tick), 1);
    wait_n(10); chk("s5_back_div", int'(tick), 1);
`endif

    wait_n(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
